ahb_apb_bridge_ctrl: RTL and testbench
======================================

# ahb_apb_bridge_ctrl

Parametrised AHB-to-APB bridge controller, the successor to the single-slave, fixed-width bridge FSM. It takes address-phase information already decoded by the AHB slave interface (Valid, Haddr, Tempselx) and drives an APB master port with any slave count and any bus width. Writes are posted into a WBUF_DEPTH-entry buffer. Reads stall the AHB data phase until the buffer drains. The block adds PREADY wait states, PSLVERR reporting, and back-to-back APB transfers.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NSLV, 3, number of APB slaves; width of the one-hot select
- WBUF_DEPTH, 2, posted-write entries (≥1)

- Hclk  in  1  clock; everything is sampled on the rising edge
- Hreset  in  1  asynchronous, active-low reset
- Valid  in  1  AHB transfer request in the address phase
- Haddr  in  ADDR_W  address-phase address
- Hwrite  in  1  address-phase direction (1 = write)
- Tempselx  in  NSLV  one-hot slave decode for Haddr
- Hwdata  in  DATA_W  data-phase write data
- Hreadyout  out  1  AHB ready
- Hresp  out  1  AHB response (1 = ERROR)
- Hrdata  out  DATA_W  read data
- Pselx  out  NSLV  APB select
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Pwrite  out  1  APB direction
- Penable  out  1  APB enable
- Pready  in  1  APB ready
- Pslverr  in  1  APB slave error
- Prdata  in  DATA_W  APB read data
- Werr  out  1  sticky posted-write error flag
- Werr_clr  in  1  synchronous clear for Werr

## Operation
- A transfer is accepted when Valid=1 and Hreadyout=1. On acceptance the block captures Haddr, Hwrite and Tempselx.
- AHB-side FSM states:
  - A_IDLE: Hreadyout=1, Hresp=0.
  - A_WDATA: write data phase. Hreadyout = (count < WBUF_DEPTH). When Hreadyout=1, {addr, sel, Hwdata} is pushed. Hwdata is held by the master while Hreadyout=0.
  - A_RWAIT: Hreadyout=0.
  - A_ERR1: Hreadyout=0, Hresp=1.
  - A_ERR2: Hreadyout=1, Hresp=1.
- Any state with Hreadyout=1 can accept a new transfer: a write goes to A_WDATA, a read goes to A_RWAIT, otherwise the FSM goes to A_IDLE.
- APB-side FSM states:
  - P_IDLE: all P* controls are 0.
  - P_SETUP: Pselx = entry sel, Penable=0, Paddr/Pwrite/Pwdata driven.
  - P_ACCESS: Penable=1; held while Pready=0.
- APB-side priority:
  - Buffered writes are always issued before a pending read (program order).
  - A read is issued only when count=0 and the engine is idle or completing.
- On Pready in P_ACCESS:
  - The write entry is popped.
  - If more work exists, go straight to P_SETUP with no idle cycle; otherwise go to P_IDLE.
- Read completion with Pslverr=0: Hrdata ← Prdata, then A_RWAIT→A_IDLE.
- Read completion with Pslverr=1: A_RWAIT→A_ERR1→A_ERR2. Hrdata is unchanged.
- Write completion with Pslverr=1 sets Werr. Werr stays set until Werr_clr; set has priority over a simultaneous clear.
- An accepted transfer with Tempselx=0 produces no APB cycle:
  - Read: error response.
  - Write: data is discarded and Werr is set.
- Push and pop in the same cycle leave count unchanged.

## Timing
- Reset (asynchronous assert) values: Hreadyout=1, Hresp=0, Hrdata=0, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Werr=0. The buffer is emptied and both FSMs go to idle.
- Reset asserted mid-operation aborts the APB cycle immediately and discards buffered writes.
- Hreadyout and Hresp decode only state registers and count. There is no combinational path from Pready, Pslverr or Prdata to any output.
- Write with an empty buffer: accepted at T0, pushed at T1, P_SETUP at T2, P_ACCESS at T3.
- Read with zero wait states and an empty buffer: accepted at T0, P_SETUP at T1, P_ACCESS at T2 (Pready=1), Hreadyout=1 with Hrdata valid at T3.
- Each Pready=0 cycle adds one cycle to the read latency.

## Structure
- Package bridge_pkg holds the A_*/P_* state encodings and the HRESP_OKAY/HRESP_ERROR constants.
- Sub-module apb_wbuf: a synchronous FIFO of width ADDR_W+NSLV+DATA_W and depth WBUF_DEPTH, with full, empty and count outputs and a wrap-around pointer.

## Test plan
- Single write: addr 0x10, sel 3'b010, data 0xA5A5A5A5, Pready=1 → Pselx=010 at T2, Penable=1 at T3, Hreadyout never drops.
- Three back-to-back writes with WBUF_DEPTH=2 and Pready held 0 for 5 cycles → the third data phase stalls (Hreadyout=0) until the first pop; APB transfers run in order with no P_IDLE between them.
- Write to 0x20 then read from 0x20 → APB read issues only after the write's P_ACCESS completes; Hrdata = Prdata 0xDEADBEEF.
- Read with Pslverr=1 and 2 wait states → A_ERR1 (Hreadyout=0, Hresp=1) then A_ERR2 (Hreadyout=1, Hresp=1); Hrdata unchanged.
- Write with Pslverr=1 → Werr=1 and held; Werr_clr pulse → Werr=0. Transfer with Tempselx=0 → no Pselx activity, Werr=1.
- Hreset low during P_ACCESS with 2 entries buffered → all outputs return to reset values asynchronously; after release, count=0 and no stale APB cycle appears.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared state encodings and response codes for the AHB-to-APB bridge controller.
package bridge_pkg;

  typedef enum logic [2:0] {
    A_IDLE,
    A_WDATA,
    A_RWAIT,
    A_ERR1,
    A_ERR2
  } ahb_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SETUP,
    P_ACCESS
  } apb_state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_wbuf.sv
// Posted-write buffer: synchronous FIFO with wrap-around pointers and an occupancy count.
module apb_wbuf #(
  parameter  int WIDTH = 67,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-to-APB bridge controller: posted writes through apb_wbuf, stalled reads,
// PREADY wait states, PSLVERR reporting and back-to-back APB transfers.
module ahb_apb_bridge_ctrl
  import bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NSLV       = 3,
  parameter int WBUF_DEPTH = 2
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              Valid,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic              Hwrite,
  input  logic [NSLV-1:0]   Tempselx,
  input  logic [DATA_W-1:0] Hwdata,
  output logic              Hreadyout,
  output logic              Hresp,
  output logic [DATA_W-1:0] Hrdata,
  output logic [NSLV-1:0]   Pselx,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Pwrite,
  output logic              Penable,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata,
  output logic              Werr,
  input  logic              Werr_clr
);

  localparam int ENTRY_W = ADDR_W + NSLV + DATA_W;
  localparam int CNT_W   = $clog2(WBUF_DEPTH + 1);

  ahb_state_e        a_q, a_d;
  apb_state_e        p_q, p_d;
  logic              p_write_q, p_write_d;
  logic              rd_launched_q, rd_launched_d;
  logic [ADDR_W-1:0] addr_q;
  logic [NSLV-1:0]   sel_q;
  logic [DATA_W-1:0] hrdata_q;
  logic              werr_q;

  logic              hready, accept, wr_done, push, pop, apb_done, rd_done, rd_pend, werr_set;
  logic              launch_wr, launch_rd;
  logic              wb_full, wb_empty;
  logic [CNT_W-1:0]  wb_count, cnt_after;
  logic [ENTRY_W-1:0] wb_rdata;
  logic [ADDR_W-1:0] head_addr;
  logic [NSLV-1:0]   head_sel;
  logic [DATA_W-1:0] head_data;

  apb_wbuf #(.WIDTH(ENTRY_W), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk    (Hclk),
    .rst_n  (Hreset),
    .push_i (push),
    .wdata_i({addr_q, sel_q, Hwdata}),
    .pop_i  (pop),
    .rdata_o(wb_rdata),
    .full_o (wb_full),
    .empty_o(wb_empty),
    .count_o(wb_count)
  );

  assign {head_addr, head_sel, head_data} = wb_rdata;

  // Ready decodes only AHB state and buffer occupancy, never APB inputs.
  assign hready   = (a_q == A_IDLE) || (a_q == A_ERR2) || ((a_q == A_WDATA) && !wb_full);
  assign accept   = Valid && hready;
  assign wr_done  = (a_q == A_WDATA) && hready;
  assign push     = wr_done && (|sel_q);
  assign apb_done = (p_q == P_ACCESS) && Pready;
  assign pop      = apb_done && p_write_q;
  assign rd_done  = apb_done && !p_write_q;
  assign rd_pend  = (a_q == A_RWAIT) && !rd_launched_q;
  assign cnt_after = wb_count - CNT_W'(pop) + CNT_W'(push);
  assign werr_set = (pop && Pslverr) || (wr_done && !(|sel_q));

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    a_d = a_q;
    case (a_q)
      A_RWAIT: if (rd_done) a_d = Pslverr ? A_ERR1 : A_IDLE;
      A_ERR1:  a_d = A_ERR2;
      default: ;
    endcase
    if (hready) begin
      if (!Valid)         a_d = A_IDLE;
      else if (Hwrite)    a_d = A_WDATA;
      else if (|Tempselx) a_d = A_RWAIT;
      else                a_d = A_ERR1;
    end
  end

  // Writes drain before a pending read; a finishing transfer chains straight into SETUP.
  always_comb begin
    p_d           = p_q;
    p_write_d     = p_write_q;
    rd_launched_d = rd_launched_q;
    launch_wr     = 1'b0;
    launch_rd     = 1'b0;
    case (p_q)
      P_IDLE: begin
        launch_wr = !wb_empty;
        launch_rd = wb_empty && rd_pend;
      end
      P_SETUP: p_d = P_ACCESS;
      P_ACCESS: begin
        if (Pready) begin
          launch_wr = (cnt_after != '0);
          launch_rd = (cnt_after == '0) && rd_pend;
          if (!launch_wr && !launch_rd) p_d = P_IDLE;
        end
      end
      default: p_d = P_IDLE;
    endcase
    if (launch_wr || launch_rd) begin
      p_d       = P_SETUP;
      p_write_d = launch_wr;
    end
    if (launch_rd)    rd_launched_d = 1'b1;
    else if (rd_done) rd_launched_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge Hclk or negedge Hreset) begin
    if (!Hreset) begin
      a_q           <= A_IDLE;
      p_q           <= P_IDLE;
      p_write_q     <= 1'b0;
      rd_launched_q <= 1'b0;
      addr_q        <= '0;
      sel_q         <= '0;
      hrdata_q      <= '0;
      werr_q        <= 1'b0;
    end else begin
      a_q           <= a_d;
      p_q           <= p_d;
      p_write_q     <= p_write_d;
      rd_launched_q <= rd_launched_d;
      if (accept) begin
        addr_q <= Haddr;
        sel_q  <= Tempselx;
      end
      if (rd_done && !Pslverr) hrdata_q <= Prdata;
      if (werr_set)      werr_q <= 1'b1;
      else if (Werr_clr) werr_q <= 1'b0;
    end
  end

  // Write transfers read the buffer head, which stays put until its own completion pops it.
  always_comb begin
    Pselx  = '0;
    Paddr  = '0;
    Pwdata = '0;
    Pwrite = 1'b0;
    if (p_q != P_IDLE) begin
      if (p_write_q) begin
        Pselx  = head_sel;
        Paddr  = head_addr;
        Pwdata = head_data;
        Pwrite = 1'b1;
      end else begin
        Pselx = sel_q;
        Paddr = addr_q;
      end
    end
  end

  assign Penable   = (p_q == P_ACCESS);
  assign Hreadyout = hready;
  assign Hresp     = ((a_q == A_ERR1) || (a_q == A_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign Hrdata    = hrdata_q;
  assign Werr      = werr_q;

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Directed bench for ahb_apb_bridge_ctrl: posted writes, stalled reads, errors and reset abort.
module tb_ahb_apb_bridge_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NSLV   = 3;

  logic              Hclk = 1'b0;
  logic              Hreset;
  logic              Valid;
  logic [ADDR_W-1:0] Haddr;
  logic              Hwrite;
  logic [NSLV-1:0]   Tempselx;
  logic [DATA_W-1:0] Hwdata;
  logic              Hreadyout, Hresp;
  logic [DATA_W-1:0] Hrdata;
  logic [NSLV-1:0]   Pselx;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Pwrite, Penable;
  logic              Pready, Pslverr;
  logic [DATA_W-1:0] Prdata;
  logic              Werr, Werr_clr;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_apb_bridge_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .WBUF_DEPTH(2)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Valid(Valid), .Haddr(Haddr), .Hwrite(Hwrite),
    .Tempselx(Tempselx), .Hwdata(Hwdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
    .Hrdata(Hrdata), .Pselx(Pselx), .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite),
    .Penable(Penable), .Pready(Pready), .Pslverr(Pslverr), .Prdata(Prdata),
    .Werr(Werr), .Werr_clr(Werr_clr)
  );

  always #5 Hclk = ~Hclk;

  // Log of completed APB transfers, in completion order.
  logic [ADDR_W-1:0] log_addr [64];
  logic [DATA_W-1:0] log_data [64];
  logic              log_wr   [64];
  int                n_log = 0;

  always @(posedge Hclk) begin
    if (Hreset === 1'b1 && Penable === 1'b1 && Pready === 1'b1 && n_log < 64) begin
      log_addr[n_log] = Paddr;
      log_data[n_log] = Pwdata;
      log_wr[n_log]   = Pwrite;
      n_log++;
    end
  end

  task automatic start_xfer(input logic wr, input logic [ADDR_W-1:0] a, input logic [NSLV-1:0] sel);
    Valid = 1'b1; Hwrite = wr; Haddr = a; Tempselx = sel;
  endtask

  task automatic stop_xfer;
    Valid = 1'b0; Hwrite = 1'b0; Haddr = '0; Tempselx = '0;
  endtask

  task automatic test_reset;
    Hreset = 1'b0;
    stop_xfer();
    Hwdata = '0; Pready = 1'b1; Pslverr = 1'b0; Prdata = '0; Werr_clr = 1'b0;
    repeat (2) @(negedge Hclk);
    n_tests++; if (Hreadyout !== 1'b1) begin n_fail++; $display("FAIL rst_hready: got %b want 1", Hreadyout); end
    n_tests++; if (Hresp !== 1'b0) begin n_fail++; $display("FAIL rst_hresp: got %b want 0", Hresp); end
    n_tests++; if (Hrdata !== 32'h0) begin n_fail++; $display("FAIL rst_hrdata: got %h want 0", Hrdata); end
    n_tests++; if (Pselx !== 3'b000) begin n_fail++; $display("FAIL rst_psel: got %b want 000", Pselx); end
    n_tests++; if (Penable !== 1'b0) begin n_fail++; $display("FAIL rst_penable: got %b want 0", Penable); end
    n_tests++; if (Pwrite !== 1'b0) begin n_fail++; $display("FAIL rst_pwrite: got %b want 0", Pwrite); end
    n_tests++; if (Paddr !== 32'h0) begin n_fail++; $display("FAIL rst_paddr: got %h want 0", Paddr); end
    n_tests++; if (Pwdata !== 32'h0) begin n_fail++; $display("FAIL rst_pwdata: got %h want 0", Pwdata); end
    n_tests++; if (Werr !== 1'b0) begin n_fail++; $display("FAIL rst_werr: got %b want 0", Werr); end
    Hreset = 1'b1;
    @(negedge Hclk);
    n_tests++; if (Hreadyout !== 1'b1 || Pselx !== 3'b000) begin
      n_fail++; $display("FAIL rst_release_idle: got hready=%b psel=%b want 1/000", Hreadyout, Pselx);
    end
  endtask

  task automatic test_single_write;
    int drops = 0;
    @(negedge Hclk); start_xfer(1'b1, 32'h10, 3'b010);
    @(negedge Hclk);                                  // after T0
    if (Hreadyout !== 1'b1) drops++;
    n_tests++; if (Pselx !== 3'b000) begin n_fail++; $display("FAIL sw_t0_psel: got %b want 000", Pselx); end
    stop_xfer(); Hwdata = 32'hA5A5_A5A5;
    @(negedge Hclk);                                  // after T1: pushed
    if (Hreadyout !== 1'b1) drops++;
    n_tests++; if (Pselx !== 3'b000) begin n_fail++; $display("FAIL sw_t1_psel: got %b want 000", Pselx); end
    Hwdata = '0;
    @(negedge Hclk);                                  // after T2: SETUP
    if (Hreadyout !== 1'b1) drops++;
    n_tests++; if (Pselx !== 3'b010 || Penable !== 1'b0) begin
      n_fail++; $display("FAIL sw_setup: got psel=%b pen=%b want 010/0", Pselx, Penable);
    end
    n_tests++; if (Paddr !== 32'h10 || Pwrite !== 1'b1 || Pwdata !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL sw_setup_bus: got addr=%h wr=%b data=%h want 10/1/a5a5a5a5", Paddr, Pwrite, Pwdata);
    end
    @(negedge Hclk);                                  // after T3: ACCESS
    if (Hreadyout !== 1'b1) drops++;
    n_tests++; if (Penable !== 1'b1 || Pselx !== 3'b010) begin
      n_fail++; $display("FAIL sw_access: got pen=%b psel=%b want 1/010", Penable, Pselx);
    end
    @(negedge Hclk);                                  // after T4: back to idle
    if (Hreadyout !== 1'b1) drops++;
    n_tests++; if (Pselx !== 3'b000 || Penable !== 1'b0) begin
      n_fail++; $display("FAIL sw_idle: got psel=%b pen=%b want 000/0", Pselx, Penable);
    end
    n_tests++; if (drops !== 0) begin n_fail++; $display("FAIL sw_hready_drop: got %0d drops want 0", drops); end
  endtask

  task automatic test_back_to_back;
    int base = n_log;
    int stall = 0, gaps = 0, waits = 0;
    logic [ADDR_W-1:0] exp_a [3];
    logic [DATA_W-1:0] exp_d [3];
    exp_a[0] = 32'h100; exp_a[1] = 32'h104; exp_a[2] = 32'h108;
    exp_d[0] = 32'h1111_0001; exp_d[1] = 32'h2222_0002; exp_d[2] = 32'h3333_0003;
    Pready = 1'b0;
    @(negedge Hclk); start_xfer(1'b1, exp_a[0], 3'b001);
    @(negedge Hclk); Hwdata = exp_d[0]; start_xfer(1'b1, exp_a[1], 3'b010);   // after T0
    @(negedge Hclk);                                                         // after T1
    n_tests++; if (Hreadyout !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ready: got %b want 1", Hreadyout); end
    Hwdata = exp_d[1]; start_xfer(1'b1, exp_a[2], 3'b100);
    @(negedge Hclk);                                                         // after T2
    n_tests++; if (Hreadyout !== 1'b0) begin n_fail++; $display("FAIL b2b_third_stall: got %b want 0", Hreadyout); end
    n_tests++; if (Pselx !== 3'b001) begin n_fail++; $display("FAIL b2b_first_setup: got %b want 001", Pselx); end
    Hwdata = exp_d[2]; stop_xfer();
    for (int i = 0; i < 40 && n_log < base + 3; i++) begin
      @(negedge Hclk);
      if (Hreadyout === 1'b0) stall++;
      if (n_log < base + 3 && Pselx === 3'b000) gaps++;
      if (Penable === 1'b1 && Pready === 1'b0) begin
        waits++;
        if (waits == 5) Pready = 1'b1;
      end
    end
    n_tests++; if (n_log !== base + 3) begin n_fail++; $display("FAIL b2b_timeout: got %0d transfers want 3", n_log - base); end
    n_tests++; if (stall !== 5) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 5", stall); end
    n_tests++; if (gaps !== 0) begin n_fail++; $display("FAIL b2b_idle_gap: got %0d want 0", gaps); end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (log_addr[base+k] !== exp_a[k] || log_data[base+k] !== exp_d[k] || log_wr[base+k] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_order_%0d: got addr=%h data=%h wr=%b want %h/%h/1", k,
                 log_addr[base+k], log_data[base+k], log_wr[base+k], exp_a[k], exp_d[k]);
      end
    end
    Pready = 1'b1; Hwdata = '0;
    @(negedge Hclk);
  endtask

  task automatic test_write_then_read;
    int base = n_log;
    int stall = 1, rd_before = -1;
    logic done = 1'b0, rd_seen = 1'b0;
    Prdata = 32'hDEAD_BEEF;
    @(negedge Hclk); start_xfer(1'b1, 32'h20, 3'b001);
    @(negedge Hclk); Hwdata = 32'h1234_5678; start_xfer(1'b0, 32'h20, 3'b001);  // after T0
    @(negedge Hclk); stop_xfer(); Hwdata = '0;                                   // after T1
    n_tests++; if (Hreadyout !== 1'b0) begin n_fail++; $display("FAIL wr_rd_stall: got %b want 0", Hreadyout); end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge Hclk);
      if (!rd_seen && Pselx !== 3'b000 && Pwrite === 1'b0) begin
        rd_seen = 1'b1; rd_before = n_log - base;
      end
      if (Hreadyout === 1'b1) done = 1'b1;
      else stall++;
    end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL wr_rd_timeout: got no ready want ready"); end
    n_tests++; if (stall !== 5) begin n_fail++; $display("FAIL wr_rd_latency: got %0d stall cycles want 5", stall); end
    n_tests++; if (rd_before !== 1) begin n_fail++; $display("FAIL wr_rd_order: got %0d writes done at read setup want 1", rd_before); end
    n_tests++; if (Hrdata !== 32'hDEAD_BEEF || Hresp !== 1'b0) begin
      n_fail++; $display("FAIL wr_rd_data: got %h resp=%b want deadbeef/0", Hrdata, Hresp);
    end
    n_tests++; if (log_wr[base] !== 1'b1 || log_addr[base] !== 32'h20 || log_data[base] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL wr_rd_write_xfer: got wr=%b addr=%h data=%h want 1/20/12345678", log_wr[base], log_addr[base], log_data[base]);
    end
    n_tests++; if (log_wr[base+1] !== 1'b0 || log_addr[base+1] !== 32'h20) begin
      n_fail++; $display("FAIL wr_rd_read_xfer: got wr=%b addr=%h want 0/20", log_wr[base+1], log_addr[base+1]);
    end
  endtask

  task automatic test_read_error;
    Prdata = 32'h0BAD_0BAD; Pready = 1'b0;
    @(negedge Hclk); start_xfer(1'b0, 32'h30, 3'b100);
    @(negedge Hclk); stop_xfer();                                       // after T0
    n_tests++; if (Hreadyout !== 1'b0 || Hresp !== 1'b0) begin
      n_fail++; $display("FAIL rerr_wait: got hready=%b resp=%b want 0/0", Hreadyout, Hresp);
    end
    @(negedge Hclk);                                                    // after T1: SETUP
    n_tests++; if (Pselx !== 3'b100 || Penable !== 1'b0 || Pwrite !== 1'b0 || Paddr !== 32'h30) begin
      n_fail++; $display("FAIL rerr_setup: got psel=%b pen=%b wr=%b addr=%h want 100/0/0/30", Pselx, Penable, Pwrite, Paddr);
    end
    @(negedge Hclk);                                                    // after T2: ACCESS
    @(negedge Hclk);                                                    // after T3: wait 1
    n_tests++; if (Penable !== 1'b1 || Hreadyout !== 1'b0) begin
      n_fail++; $display("FAIL rerr_waitstate: got pen=%b hready=%b want 1/0", Penable, Hreadyout);
    end
    @(negedge Hclk); Pready = 1'b1; Pslverr = 1'b1;                    // after T4: wait 2
    @(negedge Hclk); Pslverr = 1'b0;                                    // after T5: ERR1
    n_tests++; if (Hreadyout !== 1'b0 || Hresp !== 1'b1 || Pselx !== 3'b000) begin
      n_fail++; $display("FAIL rerr_err1: got hready=%b resp=%b psel=%b want 0/1/000", Hreadyout, Hresp, Pselx);
    end
    @(negedge Hclk);                                                    // after T6: ERR2
    n_tests++; if (Hreadyout !== 1'b1 || Hresp !== 1'b1) begin
      n_fail++; $display("FAIL rerr_err2: got hready=%b resp=%b want 1/1", Hreadyout, Hresp);
    end
    n_tests++; if (Hrdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rerr_hrdata_kept: got %h want deadbeef", Hrdata); end
    @(negedge Hclk);                                                    // after T7
    n_tests++; if (Hresp !== 1'b0 || Hreadyout !== 1'b1) begin
      n_fail++; $display("FAIL rerr_recover: got resp=%b hready=%b want 0/1", Hresp, Hreadyout);
    end
  endtask

  task automatic test_werr;
    int base, act = 0;
    @(negedge Hclk); start_xfer(1'b1, 32'h40, 3'b010);
    @(negedge Hclk); stop_xfer(); Hwdata = 32'hCAFE_0001;   // after T0
    @(negedge Hclk); Hwdata = '0;                             // after T1
    @(negedge Hclk);                                          // after T2
    @(negedge Hclk);                                          // after T3: ACCESS
    n_tests++; if (Werr !== 1'b0) begin n_fail++; $display("FAIL werr_before: got %b want 0", Werr); end
    Pslverr = 1'b1;
    @(negedge Hclk); Pslverr = 1'b0;                          // after T4
    n_tests++; if (Werr !== 1'b1) begin n_fail++; $display("FAIL werr_set: got %b want 1", Werr); end
    @(negedge Hclk);
    n_tests++; if (Werr !== 1'b1) begin n_fail++; $display("FAIL werr_sticky: got %b want 1", Werr); end
    Werr_clr = 1'b1;
    @(negedge Hclk); Werr_clr = 1'b0;
    n_tests++; if (Werr !== 1'b0) begin n_fail++; $display("FAIL werr_clear: got %b want 0", Werr); end
    base = n_log;
    start_xfer(1'b1, 32'h50, 3'b000);
    @(negedge Hclk); stop_xfer(); Hwdata = 32'h5555_5555;     // after T0
    @(negedge Hclk); Hwdata = '0;                             // after T1: discarded
    n_tests++; if (Werr !== 1'b1) begin n_fail++; $display("FAIL nosel_wr_werr: got %b want 1", Werr); end
    repeat (4) begin
      @(negedge Hclk);
      if (Pselx !== 3'b000 || Penable !== 1'b0) act++;
    end
    n_tests++; if (act !== 0 || n_log !== base) begin
      n_fail++; $display("FAIL nosel_wr_apb: got %0d active cycles %0d transfers want 0/0", act, n_log - base);
    end
    Werr_clr = 1'b1;
    @(negedge Hclk);
    start_xfer(1'b1, 32'h54, 3'b000);                         // clear still held across this write
    @(negedge Hclk); stop_xfer();                             // after T0
    n_tests++; if (Werr !== 1'b0) begin n_fail++; $display("FAIL werr_cleared_again: got %b want 0", Werr); end
    @(negedge Hclk); Werr_clr = 1'b0;                         // after T1: set and clear together
    n_tests++; if (Werr !== 1'b1) begin n_fail++; $display("FAIL werr_set_priority: got %b want 1", Werr); end
    start_xfer(1'b0, 32'h60, 3'b000);
    @(negedge Hclk); stop_xfer();                             // after T0
    n_tests++; if (Hreadyout !== 1'b0 || Hresp !== 1'b1 || Pselx !== 3'b000) begin
      n_fail++; $display("FAIL nosel_rd_err1: got hready=%b resp=%b psel=%b want 0/1/000", Hreadyout, Hresp, Pselx);
    end
    @(negedge Hclk);
    n_tests++; if (Hreadyout !== 1'b1 || Hresp !== 1'b1 || Pselx !== 3'b000) begin
      n_fail++; $display("FAIL nosel_rd_err2: got hready=%b resp=%b psel=%b want 1/1/000", Hreadyout, Hresp, Pselx);
    end
    @(negedge Hclk);
  endtask

  task automatic test_reset_mid;
    int base, act = 0;
    Pready = 1'b0;
    @(negedge Hclk); start_xfer(1'b1, 32'h70, 3'b001);
    @(negedge Hclk); Hwdata = 32'hAAAA_0070; start_xfer(1'b1, 32'h74, 3'b010);  // after T0
    @(negedge Hclk); Hwdata = 32'hBBBB_0074; stop_xfer();                        // after T1
    @(negedge Hclk);                                                             // after T2
    @(negedge Hclk);                                                             // after T3: ACCESS, 2 buffered
    n_tests++; if (Penable !== 1'b1 || Werr !== 1'b1 || Hrdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rmid_pre: got pen=%b werr=%b hrdata=%h want 1/1/deadbeef", Penable, Werr, Hrdata);
    end
    #2 Hreset = 1'b0;
    #1;
    n_tests++; if (Pselx !== 3'b000 || Penable !== 1'b0 || Pwrite !== 1'b0) begin
      n_fail++; $display("FAIL rmid_apb_ctrl: got psel=%b pen=%b wr=%b want 000/0/0", Pselx, Penable, Pwrite);
    end
    n_tests++; if (Paddr !== 32'h0 || Pwdata !== 32'h0) begin
      n_fail++; $display("FAIL rmid_apb_bus: got addr=%h data=%h want 0/0", Paddr, Pwdata);
    end
    n_tests++; if (Hreadyout !== 1'b1 || Hresp !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ahb: got hready=%b resp=%b want 1/0", Hreadyout, Hresp);
    end
    n_tests++; if (Hrdata !== 32'h0 || Werr !== 1'b0) begin
      n_fail++; $display("FAIL rmid_regs: got hrdata=%h werr=%b want 0/0", Hrdata, Werr);
    end
    @(negedge Hclk); @(negedge Hclk);
    Pready = 1'b1; Hwdata = '0; Hreset = 1'b1;
    base = n_log;
    repeat (6) begin
      @(negedge Hclk);
      if (Pselx !== 3'b000 || Penable !== 1'b0) act++;
    end
    n_tests++; if (act !== 0 || n_log !== base) begin
      n_fail++; $display("FAIL rmid_stale: got %0d active cycles %0d transfers want 0/0", act, n_log - base);
    end
    start_xfer(1'b1, 32'h80, 3'b100);
    @(negedge Hclk); stop_xfer(); Hwdata = 32'h0808_0808;    // after T0
    @(negedge Hclk); Hwdata = '0;                             // after T1
    @(negedge Hclk);                                          // after T2: fresh write only
    n_tests++; if (Pselx !== 3'b100 || Paddr !== 32'h80 || Pwdata !== 32'h0808_0808) begin
      n_fail++; $display("FAIL rmid_fresh: got psel=%b addr=%h data=%h want 100/80/08080808", Pselx, Paddr, Pwdata);
    end
    repeat (3) @(negedge Hclk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_write_then_read();
    test_read_error();
    test_werr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
